complex_exe_pipe: RTL and testbench

Fixed-latency, elastic result pipeline sitting directly downstream of the combinational complex ALU (multiply/divide) in the complex execute lane. It captures the ALU's double-width result and flags along with the instruction's destination tag and active-list ID, and carries them through `CX_LATENCY` register stages. This models multi-cycle mult/div timing. It then presents a valid/ready packet to writeback. Per-stage backpressure collapses bubbles, branch recovery flushes every in-flight entry, and divide-by-zero is flagged as an exception.

---
 rtl/complex_exe_pipe_pkg.sv | 40 ++++
 rtl/cx_pipe_slot.sv | 34 +++
 rtl/complex_exe_pipe.sv | 103 ++++++++++
 tb/tb_complex_exe_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_exe_pipe_pkg.sv
// Shared types and helpers for the complex execute result pipeline.
package complex_exe_pipe_pkg;

    localparam int SIZE_OPCODE_I       = 8;
    localparam int SIZE_DATA           = 32;
    localparam int EXECUTION_FLAGS     = 6;
    localparam int SIZE_PHYSICAL_LOG   = 7;
    localparam int SIZE_ACTIVELIST_LOG = 5;

    // Flag bit raised when the instruction must trap at retire.
    localparam int CX_FLAG_EXCEPTION = 1;

    // Complex-lane opcodes (multiply / divide family).
    typedef enum logic [SIZE_OPCODE_I-1:0] {
        MULT_L  = 8'h10,
        MULT_H  = 8'h11,
        MULTU_L = 8'h12,
        MULTU_H = 8'h13,
        DIV_L   = 8'h14,
        DIV_H   = 8'h15,
        DIVU_L  = 8'h16,
        DIVU_H  = 8'h17
    } cx_opcode_e;

    // Payload carried by every pipeline slot.
    typedef struct packed {
        logic [2*SIZE_DATA-1:0]           result;
        logic [EXECUTION_FLAGS-1:0]       flags;
        logic [SIZE_PHYSICAL_LOG-1:0]     dest_tag;
        logic [SIZE_ACTIVELIST_LOG-1:0]   al_id;
    } cx_pkt_t;

    localparam int CX_PKT_W = $bits(cx_pkt_t);

    // True for any signed/unsigned, low/high divide.
    function automatic logic cx_is_div(input logic [SIZE_OPCODE_I-1:0] op);
        return (op == DIV_L) || (op == DIV_H) || (op == DIVU_L) || (op == DIVU_H);
    endfunction

endpackage

// File: rtl/cx_pipe_slot.sv
// One pipeline stage: valid bit plus payload register.
// Flush only kills the valid bit; the payload is don't-care once invalid.
module cx_pipe_slot
    import complex_exe_pipe_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                ld,
    input  logic                in_vld,
    input  logic [CX_PKT_W-1:0] in_pkt,
    output logic                vld,
    output logic [CX_PKT_W-1:0] pkt
);

    // Valid bit: cleared by reset or flush, otherwise follows the upstream valid on load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vld <= 1'b0;
        else if (flush)
            vld <= 1'b0;
        else if (ld)
            vld <= in_vld;
    end

    // Payload: only captured when a real packet arrives, so bubbles do not toggle it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pkt <= '0;
        else if (ld && in_vld)
            pkt <= in_pkt;
    end

endmodule

// File: rtl/complex_exe_pipe.sv
// Fixed-latency elastic result pipe behind the complex (mul/div) ALU.
// CX_LATENCY slots, per-stage backpressure with bubble collapse,
// recovery flush, and divide-by-zero exception tagging at capture.
// CX_LATENCY is intended to lie in 1..8.
module complex_exe_pipe
    import complex_exe_pipe_pkg::*;
#(
    parameter int CX_LATENCY = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             recover_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic [SIZE_OPCODE_I-1:0]         opcode_i,
    input  logic [SIZE_DATA-1:0]             data2_i,
    input  logic [2*SIZE_DATA-1:0]           result_i,
    input  logic [EXECUTION_FLAGS-1:0]       flags_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]     dest_tag_i,
    input  logic [SIZE_ACTIVELIST_LOG-1:0]   al_id_i,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [2*SIZE_DATA-1:0]           result_o,
    output logic [EXECUTION_FLAGS-1:0]       flags_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]     dest_tag_o,
    output logic [SIZE_ACTIVELIST_LOG-1:0]   al_id_o,
    output logic [$clog2(CX_LATENCY+1)-1:0]  occupancy_o
);

    localparam int LAST  = CX_LATENCY - 1;
    localparam int OCC_W = $clog2(CX_LATENCY + 1);

    logic [CX_LATENCY-1:0]               v;
    logic [CX_LATENCY-1:0]               ld;
    logic [CX_LATENCY-1:0][CX_PKT_W-1:0] pkt_q;
    logic                                ld_chain;
    cx_pkt_t                             cap_pkt;
    cx_pkt_t                             out_pkt;

    // Load enables, walked from the output back to stage 0.
    // ld[s] = ~v[s] | adv[s] with adv[s] = v[s] & ld[s+1] reduces to ~v[s] | ld[s+1],
    // so an empty stage always loads and a full one loads only if downstream moves.
    always_comb begin
        ld       = '0;
        ld_chain = ready_i;
        for (int s = LAST; s >= 0; s--) begin
            ld[s]    = ~v[s] | ld_chain;
            ld_chain = ld[s];
        end
    end

    assign ready_o = ld[0] & ~recover_i;

    // Capture: pass the ALU packet through, forcing the exception flag on divide-by-zero.
    always_comb begin
        cap_pkt.result   = result_i;
        cap_pkt.flags    = flags_i;
        cap_pkt.dest_tag = dest_tag_i;
        cap_pkt.al_id    = al_id_i;
        if (cx_is_div(opcode_i) && (data2_i == '0))
            cap_pkt.flags[CX_FLAG_EXCEPTION] = 1'b1;
    end

    for (genvar s = 0; s < CX_LATENCY; s++) begin : g_slot
        logic                in_vld;
        logic [CX_PKT_W-1:0] in_pkt;

        if (s == 0) begin : g_head
            assign in_vld = valid_i & ready_o;
            assign in_pkt = cap_pkt;
        end else begin : g_body
            assign in_vld = v[s-1];
            assign in_pkt = pkt_q[s-1];
        end

        cx_pipe_slot u_slot (
            .clk    (clk),
            .reset  (reset),
            .flush  (recover_i),
            .ld     (ld[s]),
            .in_vld (in_vld),
            .in_pkt (in_pkt),
            .vld    (v[s]),
            .pkt    (pkt_q[s])
        );
    end

    // Output packet comes straight from the last slot; only valid is gated by recovery.
    assign out_pkt    = pkt_q[LAST];
    assign valid_o    = v[LAST] & ~recover_i;
    assign result_o   = out_pkt.result;
    assign flags_o    = out_pkt.flags;
    assign dest_tag_o = out_pkt.dest_tag;
    assign al_id_o    = out_pkt.al_id;

    // Occupancy is the population count of the registered valid bits.
    always_comb begin
        occupancy_o = '0;
        for (int s = 0; s < CX_LATENCY; s++)
            occupancy_o = occupancy_o + OCC_W'(v[s]);
    end

endmodule

// File: tb/tb_complex_exe_pipe.sv
// Scoreboard bench for complex_exe_pipe (CX_LATENCY = 3).
module tb_complex_exe_pipe;
    import complex_exe_pipe_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        recover_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [7:0]  opcode_i = '0;
    logic [31:0] data2_i = '0;
    logic [63:0] result_i = '0;
    logic [5:0]  flags_i = '0;
    logic [6:0]  dest_tag_i = '0;
    logic [4:0]  al_id_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [63:0] result_o;
    logic [5:0]  flags_o;
    logic [6:0]  dest_tag_o;
    logic [4:0]  al_id_o;
    logic [1:0]  occupancy_o;

    complex_exe_pipe #(.CX_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .recover_i(recover_i),
        .valid_i(valid_i), .ready_o(ready_o), .opcode_i(opcode_i),
        .data2_i(data2_i), .result_i(result_i), .flags_i(flags_i),
        .dest_tag_i(dest_tag_i), .al_id_i(al_id_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .flags_o(flags_o),
        .dest_tag_o(dest_tag_o), .al_id_o(al_id_o), .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] result;
        logic [5:0]  flags;
        logic [6:0]  dest;
        logic [4:0]  al;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_pop = 0;
    int   n_push = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model for the stored flags.
    function automatic logic [5:0] model_flags(input logic [7:0] op, input logic [31:0] d2,
                                               input logic [5:0] fl);
        logic is_div;
        is_div = (op == 8'h14) || (op == 8'h15) || (op == 8'h16) || (op == 8'h17);
        return (is_div && d2 == 0) ? (fl | 6'b000010) : fl;
    endfunction

    // Scoreboard: pop/compare on output handshake, push on accept, wipe on recovery.
    always @(negedge clk) begin
        if (reset) begin
            if (recover_i) begin
                chk("recover_valid_o", valid_o, 1'b0);
                q.delete();
            end else begin
                if (valid_o && ready_i) begin
                    n_pop++;
                    if (q.size() == 0) begin
                        chk("sb_underflow", q.size(), 1);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("sb_result", result_o, e.result);
                        chk("sb_flags", flags_o, e.flags);
                        chk("sb_dest", dest_tag_o, e.dest);
                        chk("sb_al_id", al_id_o, e.al);
                    end
                end
                if (valid_i && ready_o) begin
                    exp_t e;
                    e.result = result_i;
                    e.flags  = model_flags(opcode_i, data2_i, flags_i);
                    e.dest   = dest_tag_i;
                    e.al     = al_id_i;
                    q.push_back(e);
                    n_push++;
                end
            end
        end
    end

    always @(negedge reset) q.delete();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] al, input logic [7:0] op,
                         input logic [31:0] d2, input logic [5:0] fl);
        valid_i    = 1'b1;
        al_id_i    = al;
        opcode_i   = op;
        data2_i    = d2;
        flags_i    = fl;
        dest_tag_i = 7'($urandom);
        result_i   = {$urandom(), $urandom()};
    endtask

    task automatic drain();
        int budget;
        valid_i = 1'b0;
        ready_i = 1'b1;
        budget  = 0;
        while ((occupancy_o != 0 || q.size() != 0) && budget < 50) begin
            step();
            budget++;
        end
        chk("drain_occ", occupancy_o, 0);
        chk("drain_sb", q.size(), 0);
    endtask

    int pop0, push0;

    initial begin
        // Reset state
        #2;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_occ", occupancy_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_al_id", al_id_o, 0);
        step();
        reset = 1'b1;
        #1;
        chk("rst_ready_o", ready_o, 1);

        // Back-to-back, ready_i high: first output after LAT-1 further edges
        ready_i = 1'b1;
        pop0 = n_pop;
        for (int i = 0; i < 4; i++) begin
            drive(5'(i), MULT_L, 32'd7, 6'b000001);
            step();
            chk("b2b_valid_o", valid_o, (i >= LAT - 1) ? 1 : 0);
        end
        valid_i = 1'b0;
        step(); chk("b2b_tail1", valid_o, 1);
        step(); chk("b2b_tail2", valid_o, 1);
        step(); chk("b2b_empty", valid_o, 0);
        chk("b2b_pops", n_pop - pop0, 4);

        // Fill with ready_i low
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(5'(8 + i), MULTU_H, 32'd3, 6'b0);
            step();
        end
        chk("full_ready_o", ready_o, 0);
        chk("full_occ", occupancy_o, LAT);
        chk("full_head", al_id_o, 8);
        pop0 = n_pop; push0 = n_push;
        drive(5'd12, MULT_H, 32'd1, 6'b0);
        ready_i = 1'b1;
        #1;
        chk("full_ready_pass", ready_o, 1);
        step();
        ready_i = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("full_one_pop", n_pop - pop0, 1);
        chk("full_one_push", n_push - push0, 1);
        chk("full_occ_hold", occupancy_o, LAT);
        chk("full_new_head", al_id_o, 9);
        drain();

        // Bubble collapse
        ready_i = 1'b0;
        drive(5'd20, MULT_L, 32'd1, 6'b0); step();
        valid_i = 1'b0; step();
        drive(5'd21, MULT_L, 32'd1, 6'b0); step();
        valid_i = 1'b0;
        step(); step(); step();
        chk("bub_occ", occupancy_o, 2);
        chk("bub_ready_o", ready_o, 1);
        chk("bub_head", al_id_o, 20);
        drain();

        // Divide-by-zero tagging
        ready_i = 1'b1;
        drive(5'd1, DIVU_L, 32'd0, 6'b010100); step();
        drive(5'd2, MULT_L, 32'd0, 6'b010100); step();
        drive(5'd3, DIV_H,  32'd5, 6'b010100); step();
        valid_i = 1'b0;
        chk("divz_flags", flags_o, 6'b010110);
        step();
        chk("mult_flags", flags_o, 6'b010100);
        step();
        chk("div_nz_flags", flags_o, 6'b010100);
        drain();

        // Recovery with entries in flight
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(5'(24 + i), DIV_L, 32'd9, 6'b0);
            step();
        end
        valid_i = 1'b0;
        step();
        chk("rec_occ_pre", occupancy_o, 2);
        chk("rec_valid_pre", valid_o, 1);
        recover_i = 1'b1;
        drive(5'd30, MULT_L, 32'd1, 6'b0);
        #1;
        chk("rec_valid_o", valid_o, 0);
        chk("rec_ready_o", ready_o, 0);
        step();
        recover_i = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("rec_occ_post", occupancy_o, 0);
        step();
        chk("rec_no_accept", valid_o, 0);

        // Async reset mid-stream
        ready_i = 1'b0;
        drive(5'd5, MULT_L, 32'd1, 6'b0); step();
        drive(5'd6, MULT_L, 32'd1, 6'b0); step();
        drive(5'd7, MULT_L, 32'd1, 6'b0); step();
        valid_i = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid_o", valid_o, 0);
        chk("arst_occ", occupancy_o, 0);
        chk("arst_result", result_o, 0);
        step();
        reset = 1'b1;
        ready_i = 1'b1;
        step(); step(); step();
        chk("arst_quiet", valid_o, 0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            logic [7:0] op;
            op = 8'(8'h10 + $urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0)
                drive(5'($urandom), op, ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom(),
                      6'($urandom));
            else
                valid_i = 1'b0;
            ready_i   = ($urandom_range(0, 3) != 0);
            recover_i = ($urandom_range(0, 15) == 0);
            step();
        end
        recover_i = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
